sat_round_formatter: RTL

Parametrised, pipelined output formatter for the IIR datapath. It takes a wide signed fixed-point product and applies a selectable rounding mode, then a binary-point shift. It saturates the result to a narrower signed output word and moves samples through a valid/ready handshake. It also keeps saturation statistics, a sticky flag and a counter, for tuning the filter coefficients. It replaces the combinational overflow selector at the multiplier output.

---
 rtl/sat_round_formatter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sat_round_formatter.sv
// Rounds a wide signed product, drops FRAC_SHIFT LSBs and saturates to OUT_W bits, with clip statistics.
// Latency: 2 cycles from input transfer to out_valid (S1 round/shift, S2 saturate).
// Backpressure: valid/ready with two skid-free stages; in_ready drops only when both stages hold data and out_ready=0.
module sat_round_formatter #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_round,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    input  logic             clr_stats,
    output logic             sat_sticky,
    output logic [CNT_W-1:0] sat_count
);

    // One guard bit above the input so the rounding add can never overflow.
    localparam int WW = IN_W + 1;
    localparam logic signed [WW-1:0] HALF    = WW'(1 << (FRAC_SHIFT - 1));
    localparam logic signed [WW-1:0] SAT_MAX = WW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;

    logic                    s1_vld_q, s1_vld_d;
    logic signed [WW-1:0]    s1_r_q, s1_r_d;
    logic                    s2_vld_q, s2_vld_d;
    logic [OUT_W-1:0]        s2_dat_q, s2_dat_d;
    logic                    s2_sat_q, s2_sat_d;
    logic                    sticky_q, sticky_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    s2_load;
    logic                    s1_adv;
    logic signed [WW-1:0]    x_ext;
    logic signed [WW-1:0]    addend;
    logic signed [WW-1:0]    sum;
    logic signed [WW-1:0]    rnd;
    logic [OUT_W-1:0]        sat_dat;
    logic                    sat_flag;
    logic                    clip_xfer;
    logic [CNT_W-1:0]        cnt_base;
    logic                    sticky_base;

    assign s2_load   = !s2_vld_q || out_ready;
    assign s1_adv    = s2_load || !s1_vld_q;
    assign in_ready  = s1_adv;
    assign out_valid = s2_vld_q;
    assign out_data  = s2_dat_q;
    assign out_sat   = s2_sat_q;
    assign sat_sticky = sticky_q;
    assign sat_count  = cnt_q;

    // Round-then-shift of the incoming sample; the mode travels with the sample.
    always_comb begin
        x_ext  = {in_data[IN_W-1], in_data};
        addend = '0;
        case (in_round)
            2'b01:   addend = HALF;
            2'b10:   addend = HALF - WW'(1) + {{(WW-1){1'b0}}, in_data[FRAC_SHIFT]};
            default: addend = '0;
        endcase
        sum = x_ext + addend;
        rnd = sum >>> FRAC_SHIFT;
    end

    // Clip the rounded value to the output range; negative clip is the most-negative code.
    always_comb begin
        sat_dat  = s1_r_q[OUT_W-1:0];
        sat_flag = 1'b0;
        if (s1_r_q > SAT_MAX) begin
            sat_dat  = {1'b0, {(OUT_W-1){1'b1}}};
            sat_flag = 1'b1;
        end else if (s1_r_q < SAT_MIN) begin
            sat_dat  = {1'b1, {(OUT_W-1){1'b0}}};
            sat_flag = 1'b1;
        end
    end

    // Stage next-state: S1 captures on advance, S2 captures on load; payloads only move with a valid sample.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_r_d   = s1_r_q;
        s2_vld_d = s2_vld_q;
        s2_dat_d = s2_dat_q;
        s2_sat_d = s2_sat_q;
        if (s1_adv) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_r_d = rnd;
            end
        end
        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_dat_d = sat_dat;
                s2_sat_d = sat_flag;
            end
        end
    end

    // Statistics: a clear is applied before any same-cycle clipped transfer is counted.
    always_comb begin
        clip_xfer   = s2_vld_q && out_ready && s2_sat_q;
        cnt_base    = clr_stats ? '0 : cnt_q;
        sticky_base = clr_stats ? 1'b0 : sticky_q;
        cnt_d       = cnt_base;
        sticky_d    = sticky_base;
        if (clip_xfer) begin
            sticky_d = 1'b1;
            cnt_d    = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
        end
    end

    // State registers; reset drops any in-flight samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_r_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_dat_q <= '0;
            s2_sat_q <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_r_q   <= s1_r_d;
            s2_vld_q <= s2_vld_d;
            s2_dat_q <= s2_dat_d;
            s2_sat_q <= s2_sat_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
